tri_operand_collector: RTL and testbench

Upstream feeder for the team's 3-operand carry-save adder datapath.
- Accepts a stream of WIDTH-bit operands over a valid/ready handshake and groups them into triples (x, y, z).
- Reduces each triple with a carry-save stage followed by a ripple carry-propagate stage.
- Registers the full-width sum and presents it on a valid/ready output.
- Throttles the producer so that only one triple is in flight at a time.

---
 rtl/csa_pkg.sv | 14 +
 rtl/csa3_reduce.sv | 51 +++++
 rtl/tri_operand_collector.sv | 133 +++++++++++++
 tb/tb_tri_operand_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the 3-operand carry-save feeder.
// Holds the collector FSM encoding and the default operand width.
// No logic; imported by csa3_reduce and tri_operand_collector.
package csa_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CALC    = 2'd1,
        OUT     = 2'd2
    } state_t;

endpackage

// File: rtl/csa3_reduce.sv
// Purpose: reduce three unsigned operands to their full-width sum.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, the caller registers the result.
// Ports: x, y, z (WIDTH each) in; sum (WIDTH+2) out = x + y + z, never overflows.
module csa3_reduce
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH+1:0] sum
);

    // Carry-save row: one full adder per bit, no carry chain.
    logic [WIDTH-1:0] ps;       // partial sum bits
    logic [WIDTH-1:0] gc;       // generated carries, weight 2^(i+1)

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign ps[i] = x[i] ^ y[i] ^ z[i];
            assign gc[i] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
        end
    endgenerate

    // Carry vector is WIDTH+1 bits once shifted; both addends are widened
    // to WIDTH+2 so the ripple add never truncates.
    logic [WIDTH+1:0] add_a;
    logic [WIDTH+1:0] add_b;
    logic [WIDTH+1:0] cy;       // cy[i] is the carry into bit i

    assign add_a = {2'b00, ps};
    assign add_b = {1'b0, gc, 1'b0};
    assign cy[0] = 1'b0;

    genvar j;
    generate
        for (j = 0; j < WIDTH + 2; j++) begin : g_rca
            assign sum[j] = add_a[j] ^ add_b[j] ^ cy[j];
            // The carry out of the top bit is always zero (3*(2^W-1) fits),
            // so it is not generated.
            if (j < WIDTH + 1) begin : g_cy
                assign cy[j+1] = (add_a[j] & add_b[j]) | (cy[j] & (add_a[j] ^ add_b[j]));
            end
        end
    endgenerate

endmodule

// File: rtl/tri_operand_collector.sv
// Purpose: group an operand stream into triples and present x+y+z, one triple in flight.
// Latency: third operand accepted at edge N, CALC cycle follows, out_valid from edge N+1.
// Backpressure: in_ready low in CALC/OUT; out_sum held in OUT until out_ready.
// Ports: clk, rst (async, active high), clear (sync abort), in_valid/in_data/in_ready
//        operand stream, out_valid/out_sum/out_ready result stream, slot = operands held.
module tri_operand_collector
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH+1:0] out_sum,
    input  logic             out_ready,
    output logic [1:0]       slot
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       slot_q;
    logic [1:0]       slot_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] z_q;
    logic [WIDTH+1:0] sum_q;
    logic [WIDTH+1:0] csa_sum;
    logic             load_x;
    logic             load_y;
    logic             load_z;
    logic             load_sum;

    csa3_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .x   (x_q),
        .y   (y_q),
        .z   (z_q),
        .sum (csa_sum)
    );

    // Handshake outputs come from registered state only. rst gating keeps
    // in_ready low while the block is held in reset even though the reset
    // state is COLLECT.
    assign in_ready  = (state_q == COLLECT) && !rst;
    assign out_valid = (state_q == OUT);
    assign out_sum   = sum_q;
    assign slot      = slot_q;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        load_x   = 1'b0;
        load_y   = 1'b0;
        load_z   = 1'b0;
        load_sum = 1'b0;

        if (clear) begin
            // Drops any operand offered this cycle and any pending result.
            state_d = COLLECT;
            slot_d  = 2'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        case (slot_q)
                            2'd0: begin
                                load_x = 1'b1;
                                slot_d = 2'd1;
                            end
                            2'd1: begin
                                load_y = 1'b1;
                                slot_d = 2'd2;
                            end
                            default: begin
                                load_z  = 1'b1;
                                slot_d  = 2'd0;
                                state_d = CALC;
                            end
                        endcase
                    end
                end
                CALC: begin
                    load_sum = 1'b1;
                    state_d  = OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = COLLECT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            slot_q  <= 2'd0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            // Operand registers are not touched by clear; stale values are
            // always overwritten before the next CALC.
            if (load_x) begin
                x_q <= in_data;
            end
            if (load_y) begin
                y_q <= in_data;
            end
            if (load_z) begin
                z_q <= in_data;
            end
            if (load_sum) begin
                sum_q <= csa_sum;
            end
        end
    end

endmodule

// File: tb/tb_tri_operand_collector.sv
// Purpose: self-checking bench for tri_operand_collector with a scoreboard of triple sums.
// Latency: model expects CALC one cycle after the third accept, OUT the cycle after.
// Backpressure: bench drives random in_valid/out_ready gaps in the soak phase.
module tb_tri_operand_collector;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           out_valid;
    logic [W+1:0]   out_sum;
    logic           out_ready;
    logic [1:0]     slot;

    always #5 clk = ~clk;

    tri_operand_collector #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready),
        .slot      (slot)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: 0 = collecting, 1 = computing, 2 = result offered.
    int sb[$];
    int m_state = 0;
    int m_slot  = 0;
    int m_acc   = 0;
    int n_trip  = 0;
    int n_out   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model with the
    // inputs the DUT will see at the rising edge, then return just after it.
    task automatic step();
        @(negedge clk);
        chk("in_ready", in_ready, 32'(m_state == 0));
        chk("out_valid", out_valid, 32'(m_state == 2));
        chk("slot", slot, m_slot);
        if (m_state == 2) begin
            if (sb.size() == 0) chk("sb_underflow", 0, 1);
            else                chk("out_sum", out_sum, sb[0]);
        end
        if (clear) begin
            m_state = 0;
            m_slot  = 0;
            m_acc   = 0;
            sb.delete();
        end else begin
            case (m_state)
                0: begin
                    if (in_valid) begin
                        m_acc += int'(in_data);
                        if (m_slot == 2) begin
                            sb.push_back(m_acc);
                            n_trip++;
                            m_acc   = 0;
                            m_slot  = 0;
                            m_state = 1;
                        end else begin
                            m_slot++;
                        end
                    end
                end
                1: m_state = 2;
                default: begin
                    if (out_ready) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        n_out++;
                        m_state = 0;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic run_triple(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input int exp);
        feed(a);
        feed(b);
        feed(c);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) step();
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, out_sum, exp);
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        int base_trip;
        int base_out;
        int cyc;

        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values while rst is held.
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_slot", slot, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // 1,2,3 back to back: CALC cycle, then result, then collecting again.
        out_ready = 1'b1;
        feed(8'd1);
        feed(8'd2);
        feed(8'd3);
        in_valid = 1'b0;
        chk("lat_calc_valid", out_valid, 0);
        chk("lat_calc_rdy", in_ready, 0);
        step();
        chk("lat_out_valid", out_valid, 1);
        chk("sum_123", out_sum, 6);
        step();
        chk("post_xfer_rdy", in_ready, 1);
        chk("post_xfer_valid", out_valid, 0);

        // Extremes of the operand range.
        run_triple("sum_max", 8'd255, 8'd255, 8'd255, 765);
        run_triple("sum_zero", 8'd0, 8'd0, 8'd0, 0);

        // Result held under backpressure.
        out_ready = 1'b0;
        feed(8'd10);
        feed(8'd20);
        feed(8'd30);
        in_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 60);
            chk("hold_rdy", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("hold_release_valid", out_valid, 0);
        chk("hold_release_rdy", in_ready, 1);

        // clear drops a partial triple and the operand offered with it.
        feed(8'd7);
        feed(8'd8);
        in_valid = 1'b1;
        in_data  = 8'd9;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_slot", slot, 0);
        run_triple("sum_after_clear", 8'd4, 8'd5, 8'd6, 15);

        // Asynchronous reset while computing.
        feed(8'd1);
        feed(8'd2);
        feed(8'd3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_slot", slot, 0);
        chk("arst_in_ready", in_ready, 0);
        m_state = 0;
        m_slot  = 0;
        m_acc   = 0;
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rel_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        run_triple("sum_after_rst", 8'd1, 8'd1, 8'd1, 3);

        // Random gaps on both sides over 1000 triples.
        base_trip = n_trip;
        base_out  = n_out;
        cyc       = 0;
        while (n_trip < base_trip + 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(9) < 7);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(9) < 6);
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && m_state != 0; k++) step();
        chk("rand_triples_in", n_trip - base_trip, 1000);
        chk("rand_triples_out", n_out - base_out, 1000);
        chk("rand_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
